// File: rtl/spi_eeprom_defs.sv
// spi_eeprom_defs: opcodes, state encoding and byte-sequence helper for the SPI EEPROM write controller
package spi_eeprom_defs;
  localparam int CNT_W = 20;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRITE = 8'h02;

  typedef enum logic [3:0] {
    IDLE, WREN_SETUP, WREN_SHIFT, WREN_HOLD, GAP, SETUP, SHIFT, HOLD, TWC, DONE
  } state_e;

  // Byte order of the WRITE frame: opcode, address high, address low, data.
  function automatic logic [7:0] write_byte(input logic [1:0] i, input logic [15:0] a,
                                            input logic [7:0] d);
    return (i == 2'd0) ? OP_WRITE : (i == 2'd1) ? a[15:8] : (i == 2'd2) ? a[7:0] : d;
  endfunction
endpackage

// File: rtl/spi_eeprom_ctrl.sv
// spi_eeprom_ctrl: issues WREN then WRITE(addr, data) to an SPI EEPROM via an external byte shifter,
// then waits out the write cycle; one shared down-counter times setup, hold, gap, timeout and tWC.
module spi_eeprom_ctrl
  import spi_eeprom_defs::*;
#(
  parameter int CS_SETUP   = 4,
  parameter int CS_HOLD    = 4,
  parameter int TWC_CYCLES = 250000,
  parameter int TIMEOUT    = 127
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        wr_req,
  input  logic [15:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        ld_data,
  output logic [7:0]  datain,
  input  logic        SPI_busy,
  output logic        nCS
);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] TWC_LD   = CNT_W'(TWC_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LD    = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d, idx_nx;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d, datain_q, datain_d;
  logic             ncs_q, ncs_d, ld_q, ld_d, done_q, done_d, err_q, err_d, busy_q;
  logic             byte_done;

  assign idx_nx = idx_q + 2'd1;
  // The load cycle and the one after it are blind: the shifter has not yet dropped SPI_busy.
  assign byte_done = SPI_busy && (cnt_q < TO_LD - 1'b1);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      datain_q <= '0;
      ncs_q    <= 1'b1;
      ld_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      datain_q <= datain_d;
      ncs_q    <= ncs_d;
      ld_q     <= ld_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    idx_d    = idx_q;
    addr_d   = addr_q;
    data_d   = data_q;
    datain_d = datain_q;
    ncs_d    = ncs_q;
    ld_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: if (wr_req) begin
        addr_d  = wr_addr;
        data_d  = wr_data;
        ncs_d   = 1'b0;
        cnt_d   = SETUP_LD;
        state_d = WREN_SETUP;
      end
      WREN_SETUP, SETUP: if (cnt_q == '0) begin
        ld_d     = 1'b1;
        datain_d = (state_q == WREN_SETUP) ? OP_WREN : write_byte(idx_q, addr_q, data_q);
        cnt_d    = TO_LD;
        state_d  = (state_q == WREN_SETUP) ? WREN_SHIFT : SHIFT;
      end
      WREN_SHIFT, SHIFT: begin
        if (byte_done) begin
          if (state_q == SHIFT && idx_q != 2'd3) begin
            idx_d    = idx_nx;
            ld_d     = 1'b1;
            datain_d = write_byte(idx_nx, addr_q, data_q);
            cnt_d    = TO_LD;
          end else begin
            idx_d   = '0;
            cnt_d   = HOLD_LD;
            state_d = (state_q == SHIFT) ? HOLD : WREN_HOLD;
          end
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          ncs_d   = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      WREN_HOLD: if (cnt_q == '0) begin
        ncs_d   = 1'b1;
        cnt_d   = HOLD_LD;
        state_d = GAP;
      end
      GAP: if (cnt_q == '0) begin
        ncs_d   = 1'b0;
        cnt_d   = SETUP_LD;
        state_d = SETUP;
      end
      HOLD: if (cnt_q == '0) begin
        ncs_d   = 1'b1;
        cnt_d   = TWC_LD;
        state_d = TWC;
      end
      // done is raised while in DONE so a same-cycle wr_req lands outside IDLE.
      TWC: if (cnt_q == '0) begin
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign ld_data = ld_q;
  assign datain  = datain_q;
  assign nCS     = ncs_q;
endmodule

// File: tb/tb_spi_eeprom_ctrl.sv
// tb_spi_eeprom_ctrl: directed bench for spi_eeprom_ctrl with a 64-cycle byte-shifter model attached
module tb_spi_eeprom_ctrl;
  localparam int CS_SETUP = 4, CS_HOLD = 4, TWC = 100, TMO = 127;

  logic        clk = 1'b0, nReset = 1'b0, wr_req = 1'b0, hold_low = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        busy, done, err, ld_data, nCS, SPI_busy;
  logic [7:0]  datain;

  int checks = 0, errors = 0;
  int cyc = 0, sh_cnt = 0, n_done = 0, n_err = 0, n_fall = 0, ld_bad = 0;
  int last_rise = 0, last_fall = 0, last_done = 0, last_ld = 0, last_err = 0, last_cmpl = 0;
  int min_gap = 1000000, setup_dly = 0;
  logic ncs_prev = 1'b1, armed = 1'b0;
  logic [7:0] bq[$];
  int base, d0, e0, f0;

  always #5 clk = ~clk;

  assign SPI_busy = (sh_cnt == 0) && !hold_low;

  spi_eeprom_ctrl #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .TWC_CYCLES(TWC), .TIMEOUT(TMO)) dut (
    .clk(clk), .nReset(nReset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .ld_data(ld_data), .datain(datain),
    .SPI_busy(SPI_busy), .nCS(nCS)
  );

  // Shifter model plus monitor: records loaded bytes and edge timing of nCS, done and err.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld_data) begin
      sh_cnt  <= 63;
      bq.push_back(datain);
      last_ld <= cyc;
      if (nCS) ld_bad <= ld_bad + 1;
      if (armed) begin
        setup_dly <= cyc - last_fall;
        armed     <= 1'b0;
      end
    end else if (sh_cnt != 0) begin
      sh_cnt <= sh_cnt - 1;
      if (sh_cnt == 1) last_cmpl <= cyc + 1;
    end
    if (done) begin
      n_done    <= n_done + 1;
      last_done <= cyc;
    end
    if (err) begin
      n_err    <= n_err + 1;
      last_err <= cyc;
    end
    if (ncs_prev && !nCS) begin
      n_fall    <= n_fall + 1;
      last_fall <= cyc;
      armed     <= 1'b1;
      if (last_rise != 0 && cyc - last_rise < min_gap) min_gap <= cyc - last_rise;
    end
    if (!ncs_prev && nCS) last_rise <= cyc;
    ncs_prev <= nCS;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    @(negedge clk);
    wr_req  = 1'b0;
  endtask

  task automatic wait_end();
    int b;
    b = n_done + n_err;
    for (int i = 0; i < 3000 && n_done + n_err == b; i++) @(negedge clk);
    check("wait_bound", n_done + n_err != b, 1);
  endtask

  task automatic check_frame(input string tag, input int at, input logic [15:0] a, input logic [7:0] d);
    check({tag, "_b0"}, bq.size() > at + 4 ? bq[at] : 8'hxx, 8'h06);
    check({tag, "_b1"}, bq.size() > at + 4 ? bq[at + 1] : 8'hxx, 8'h02);
    check({tag, "_b2"}, bq.size() > at + 4 ? bq[at + 2] : 8'hxx, a[15:8]);
    check({tag, "_b3"}, bq.size() > at + 4 ? bq[at + 3] : 8'hxx, a[7:0]);
    check({tag, "_b4"}, bq.size() > at + 4 ? bq[at + 4] : 8'hxx, d);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ncs", nCS, 1);
    check("rst_ld", ld_data, 0);
    check("rst_datain", datain, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    nReset = 1'b1;
    repeat (2) @(negedge clk);

    // Single write of 0xA5 to 0x1234.
    base = bq.size(); d0 = n_done; f0 = n_fall;
    write(16'h1234, 8'hA5);
    wait_end();
    repeat (2) @(negedge clk);
    check("t1_nbytes", bq.size() - base, 5);
    check_frame("t1", base, 16'h1234, 8'hA5);
    check("t1_falls", n_fall - f0, 2);
    check("t1_done", n_done - d0, 1);
    check("t1_noerr", n_err, 0);
    check("t1_twc", last_done - last_rise >= TWC, 1);
    check("t1_setup", setup_dly, CS_SETUP);
    check("t1_hold", last_rise - last_cmpl >= CS_HOLD, 1);
    check("t1_idle", busy, 0);
    check("t1_ncs", nCS, 1);

    // wr_req with 0xFFFF while shifting must not disturb the frame.
    base = bq.size(); d0 = n_done;
    write(16'h1234, 8'h5A);
    for (int i = 0; i < 2000 && bq.size() < base + 3; i++) @(negedge clk);
    check("t2_busy", busy, 1);
    write(16'hFFFF, 8'hFF);
    wait_end();
    repeat (2) @(negedge clk);
    check("t2_nbytes", bq.size() - base, 5);
    check_frame("t2", base, 16'h1234, 8'h5A);
    check("t2_done", n_done - d0, 1);

    // Shifter stuck busy: timeout on the WREN byte.
    hold_low = 1'b1;
    base = bq.size(); d0 = n_done; e0 = n_err;
    write(16'h4321, 8'h77);
    wait_end();
    check("t3_err", n_err - e0, 1);
    check("t3_err_dly", last_err - last_ld, TMO + 1);
    check("t3_ncs", nCS, 1);
    check("t3_busy", busy, 0);
    check("t3_nbytes", bq.size() - base, 1);
    hold_low = 1'b0;
    repeat (80) @(negedge clk);
    check("t3_nodone", n_done - d0, 0);

    // Reset asserted while the third load strobe is high.
    base = bq.size(); d0 = n_done; e0 = n_err;
    write(16'h1234, 8'hA5);
    for (int i = 0; i < 2000 && !(ld_data && bq.size() == base + 2); i++) @(negedge clk);
    check("t4_reach", ld_data, 1);
    nReset = 1'b0;
    #1;
    check("t4_ncs", nCS, 1);
    check("t4_ld", ld_data, 0);
    check("t4_busy", busy, 0);
    check("t4_datain", datain, 0);
    repeat (2) @(negedge clk);
    nReset = 1'b1;
    repeat (300) @(negedge clk);
    check("t4_nodone", n_done - d0, 0);
    check("t4_noerr", n_err - e0, 0);
    check("t4_idle", busy, 0);
    check("t4_ncs_hi", nCS, 1);

    // Back-to-back: request during done is dropped, the next cycle's is taken.
    base = bq.size(); d0 = n_done;
    write(16'h00FF, 8'h11);
    for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
    check("t5_done_seen", done, 1);
    wr_addr = 16'hBEEF;
    wr_data = 8'h22;
    wr_req  = 1'b1;
    @(negedge clk);
    check("t5_idle_gap", busy, 0);
    wr_addr = 16'hCAFE;
    wr_data = 8'h33;
    @(negedge clk);
    wr_req = 1'b0;
    check("t5_accept", busy, 1);
    wait_end();
    repeat (2) @(negedge clk);
    check("t5_nbytes", bq.size() - base, 10);
    check_frame("t5a", base, 16'h00FF, 8'h11);
    check_frame("t5b", base + 5, 16'hCAFE, 8'h33);
    check("t5_done", n_done - d0, 2);
    check("t5_gap", min_gap >= CS_HOLD, 1);
    check("t5_hold", last_rise - last_cmpl >= CS_HOLD, 1);

    // All-zero write, then a further write proving the byte index restarted.
    base = bq.size();
    write(16'h0000, 8'h00);
    wait_end();
    write(16'h0102, 8'h03);
    wait_end();
    repeat (2) @(negedge clk);
    check("t6_nbytes", bq.size() - base, 10);
    check_frame("t6a", base, 16'h0000, 8'h00);
    check_frame("t6b", base + 5, 16'h0102, 8'h03);
    check("ld_ncs_hi", ld_bad, 0);
    check("total_err", n_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_eeprom_ctrl.md
SPI_EEPROM_CTRL -- requirements
Module: spi_eeprom_ctrl

Interface
REQ-001 SHALL have parameter CS_SETUP, default 4: clk cycles from nCS low to first ld_data.
REQ-002 SHALL have parameter CS_HOLD, default 4: clk cycles from last byte complete to nCS high.
REQ-003 SHALL have parameter TWC_CYCLES, default 250000: write-cycle wait, 5 ms at 50 MHz; counter 20 bits.
REQ-004 SHALL have parameter TIMEOUT, default 127: maximum clk cycles to wait for one byte to complete.
REQ-005 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-006 Port nReset, input, 1: reset, asynchronous, active-low.
REQ-007 Port wr_req, input, 1: write-request pulse; sampled only in IDLE.
REQ-008 Port wr_addr, input, 16: EEPROM byte address.
REQ-009 Port wr_data, input, 8: byte to write.
REQ-010 Port busy, output, 1: high in every state except IDLE.
REQ-011 Port done, output, 1: one-cycle pulse when the write cycle completes.
REQ-012 Port err, output, 1: one-cycle pulse when a byte times out.
REQ-013 Port ld_data, output, 1: one-cycle load strobe to the byte shifter.
REQ-014 Port datain, output, 8: byte presented to the shifter; valid while ld_data is high.
REQ-015 Port SPI_busy, input, 1: shifter status; high = idle or byte complete, low = shifting (about 64 clk per byte).
REQ-016 Port nCS, output, 1: EEPROM chip select, active-low.

Function
REQ-017 States SHALL be: IDLE, WREN_SETUP, WREN_SHIFT, WREN_HOLD, GAP, SETUP, SHIFT, HOLD, TWC, DONE.
REQ-018 IDLE with wr_req=1 SHALL latch wr_addr and wr_data, drive nCS low on the next cycle, and enter WREN_SETUP.
REQ-019 WREN_SETUP SHALL count CS_SETUP cycles, then pulse ld_data with datain=0x06 and enter WREN_SHIFT.
REQ-020 Each SHIFT-type state SHALL ignore SPI_busy during the cycle after ld_data, then wait for SPI_busy=1 to mark the byte complete.
REQ-021 After WREN completes, WREN_HOLD SHALL count CS_HOLD cycles, then drive nCS high; GAP SHALL keep nCS high for CS_HOLD cycles.
REQ-022 SETUP SHALL drive nCS low for CS_SETUP cycles, then SHIFT SHALL send 0x02, wr_addr[15:8], wr_addr[7:0], wr_data in order, using a 2-bit byte index.
REQ-023 The next ld_data SHALL issue on the cycle after the previous byte completes; the index SHALL advance 0->3, and completion at index 3 SHALL enter HOLD.
REQ-024 HOLD SHALL count CS_HOLD cycles, then drive nCS high and enter TWC.
REQ-025 TWC SHALL count TWC_CYCLES cycles with nCS high, then enter DONE.
REQ-026 DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-027 Back-to-back writes: a wr_req in the same cycle as done SHALL be ignored; wr_req in IDLE one cycle later SHALL be accepted.
REQ-028 wr_req while busy=1 SHALL be ignored; latched address and data SHALL not change.
REQ-029 If a byte does not complete within TIMEOUT cycles, the block SHALL pulse err, drive nCS high, and return to IDLE without pulsing done.
REQ-030 ld_data SHALL never be high while nCS is high; outputs SHALL be registered.

Reset
REQ-031 Assertion of nReset SHALL immediately force: state IDLE, nCS=1, ld_data=0, datain=0x00, busy=0, done=0, err=0, all counters 0.
REQ-032 Reset mid-transfer SHALL abort the transfer; no done or err pulse SHALL follow.

Structure
REQ-033 Opcode constants (WREN 0x06, WRITE 0x02) and the state encoding SHALL live in a shared include/package, spi_eeprom_defs.
REQ-034 Timing counters SHALL share one down-counter; the block SHALL instantiate the existing byte shifter only in the bench, not internally.

Verification (bench TWC_CYCLES=100, shifter model attached)
REQ-035 wr_addr=0x1234, wr_data=0xA5, wr_req pulse -> MOSI bytes 06 | 02 12 34 A5; nCS low twice; done exactly once, 100+ cycles after the final nCS rise.
REQ-036 wr_req pulsed during SHIFT with addr 0xFFFF -> ignored; bytes still 12 34; single done.
REQ-037 SPI_busy held low by the model -> err pulse at TIMEOUT+1 cycles after ld_data; nCS=1; no done; busy=0.
REQ-038 nReset low during the third byte -> nCS=1 and ld_data=0 in the same cycle; after release, idle with no done.
REQ-039 Two writes, second wr_req one cycle after done -> both complete; GAP and hold spacing of at least CS_HOLD cycles is honoured.
REQ-040 Addr 0x0000, data 0x00 -> exact zero bytes sent; byte index wraps to 0 for the next write.
